// File: rtl/cache_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_mem_ctrl_if
// Bundle of the cache-to-memory protocol signals seen by cache_mem_ctrl.
//   dcache side : dREN, dWEN, daddr, dstore  -> controller
//                 dwait, dload               <- controller
//   icache side : iREN, iaddr                -> controller
//                 iwait, iload               <- controller
//   RAM side    : ramREN, ramWEN, ramaddr, ramstore <- controller
//                 ramload, ramstate                 -> controller
//   status      : err                               <- controller
// The "slave" modport is the controller's view.
// The "master" modport is the view of the caches and the RAM model.
// ---------------------------------------------------------------------------
interface cache_mem_ctrl_if;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    logic        err;

    modport slave (
        input  dREN, dWEN, daddr, dstore,
        output dwait, dload,
        input  iREN, iaddr,
        output iwait, iload,
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate,
        output err
    );

    modport master (
        output dREN, dWEN, daddr, dstore,
        input  dwait, dload,
        output iREN, iaddr,
        input  iwait, iload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate,
        input  err
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// ---------------------------------------------------------------------------
// cache_mem_ctrl
// Responder end of the cache-to-memory protocol. It arbitrates a dcache
// (read/write) and an icache (read-only) onto one single-ported RAM.
//
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - cache_mem_ctrl_if.slave: cache request/response lines,
//           RAM request/status lines and the sticky err flag
//
// Arbitration takes place in IDLE. The granted RAM request starts on the
// following cycle. dcache writes have priority over dcache reads, which have
// priority over icache reads. An icache that has waited STARVE_MAX cycles
// wins the next arbitration.
// Address and data pass straight through from the granted requester.
// The wait/load responses are combinational on ramstate, so an access
// completes in the same cycle that the RAM reports ACCESS or ERROR.
// ---------------------------------------------------------------------------
module cache_mem_ctrl #(
    parameter int          STARVE_MAX = 8,
    parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
    input  logic               CLK,
    input  logic               nRST,
    cache_mem_ctrl_if.slave    bus
);

    localparam int             CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DWR  = 2'd1,
        DRD  = 2'd2,
        IRD  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           grant_d;
    logic             ramren_q;
    logic             ramwen_q;
    logic             err_q;
    logic [CNT_W-1:0] starve_q;

    logic ram_done;
    logic ram_err;
    logic req_held;
    logic d_done;
    logic i_done;
    logic starve_full;

    assign ram_done    = (bus.ramstate == RS_ACCESS) || (bus.ramstate == RS_ERROR);
    assign ram_err     = (bus.ramstate == RS_ERROR);
    assign starve_full = (starve_q >= STARVE_LIM);

    // The granted requester's own request line. If this line drops before
    // completion, the access is abandoned.
    always_comb begin
        req_held = 1'b0;
        case (state_q)
            DWR:     req_held = bus.dWEN;
            DRD:     req_held = bus.dREN;
            IRD:     req_held = bus.iREN;
            default: req_held = 1'b0;
        endcase
    end

    // An access completes only if its request is still held. A withdrawn
    // request never produces a wait pulse, even if the RAM answers in that cycle.
    assign d_done = ((state_q == DWR) || (state_q == DRD)) && req_held && ram_done;
    assign i_done = (state_q == IRD) && req_held && ram_done;

    // Arbitration result. It is only consumed while in IDLE.
    always_comb begin
        grant_d = IDLE;
        if (starve_full && bus.iREN) begin
            grant_d = IRD;
        end else if (bus.dWEN) begin
            grant_d = DWR;
        end else if (bus.dREN) begin
            grant_d = DRD;
        end else if (bus.iREN) begin
            grant_d = IRD;
        end
    end

    // State machine with registered RAM enables. The enables track the
    // state being entered, so they rise and fall together with the grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= grant_d;
                    ramwen_q <= (grant_d == DWR);
                    ramren_q <= (grant_d == DRD) || (grant_d == IRD);
                end
                default: begin
                    // Completion or abort both return to IDLE.
                    if (!req_held || ram_done) begin
                        state_q  <= IDLE;
                        ramren_q <= 1'b0;
                        ramwen_q <= 1'b0;
                    end
                end
            endcase

            if ((d_done || i_done) && ram_err) begin
                err_q <= 1'b1;
            end

            // The counter measures how long a pending icache request has
            // been held off. It saturates so that the comparison stays valid.
            if (!bus.iREN || i_done) begin
                starve_q <= '0;
            end else if ((state_q != IRD) && (starve_q < STARVE_LIM)) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end

    // RAM request lines pass through from the granted requester.
    always_comb begin
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state_q)
            DWR: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            DRD:     bus.ramaddr = bus.daddr;
            IRD:     bus.ramaddr = bus.iaddr;
            default: bus.ramaddr = '0;
        endcase
    end

    assign bus.ramREN = ramren_q;
    assign bus.ramWEN = ramwen_q;

    assign bus.dwait  = !d_done;
    assign bus.iwait  = !i_done;
    assign bus.dload  = d_done ? (ram_err ? ERR_WORD : bus.ramload) : 32'h0;
    assign bus.iload  = i_done ? (ram_err ? ERR_WORD : bus.ramload) : 32'h0;

    assign bus.err    = err_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_ctrl
// Testbench for cache_mem_ctrl. It contains:
//   - randomized dcache and icache drivers
//   - a RAM model with random latency; addresses ending in 0xF report ERROR
//   - a reference memory that predicts every expected response
// Drivers push expected responses into per-port queues. A monitor pops an
// entry whenever a wait line drops and compares it with the DUT response.
// ---------------------------------------------------------------------------
module tb_cache_mem_ctrl;

    localparam int          STARVE_MAX = 8;
    localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

    logic clk;
    logic nrst;

    cache_mem_ctrl_if bus_if();

    cache_mem_ctrl #(
        .STARVE_MAX(STARVE_MAX),
        .ERR_WORD  (ERR_WORD)
    ) dut (
        .CLK (clk),
        .nRST(nrst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          wr;
        bit          bad;
    } exp_t;

    exp_t d_q[$];
    exp_t i_q[$];
    exp_t mon_e;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ram_mem [logic [31:0]];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int d_done_cyc  = 0;
    int i_done_cyc  = 0;
    int d_pulses    = 0;
    int max_busy    = 3;
    int busy_left   = 0;
    bit force_busy  = 0;
    bit mon_en      = 0;
    bit err_exp     = 0;
    bit i_fin       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
        return a[3:0] == 4'hF;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM model. It drives ramstate/ramload for the current cycle, just after
    // the registered enables settle.
    always @(posedge clk) begin
        #2;
        if (bus_if.ramREN || bus_if.ramWEN) begin
            if (force_busy || busy_left > 0) begin
                bus_if.ramstate = 2'd1;
                bus_if.ramload  = $urandom;
                if (!force_busy) busy_left--;
            end else if (is_bad(bus_if.ramaddr)) begin
                bus_if.ramstate = 2'd3;
                bus_if.ramload  = $urandom;
            end else begin
                bus_if.ramstate = 2'd2;
                bus_if.ramload  = ram_rd(bus_if.ramaddr);
                if (bus_if.ramWEN) ram_mem[bus_if.ramaddr] = bus_if.ramstore;
            end
        end else begin
            bus_if.ramstate = 2'd0;
            bus_if.ramload  = $urandom;
            busy_left       = $urandom_range(0, max_busy);
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en && nrst) begin
            chk("err_flag", 32'(bus_if.err), 32'(err_exp));
            if (bus_if.dwait === 1'b0) begin
                d_done_cyc = cyc;
                d_pulses++;
                if (d_q.size() == 0) begin
                    chk("d_unexpected_pulse", 32'(bus_if.dwait), 32'd1);
                end else begin
                    mon_e = d_q.pop_front();
                    chk("d_ramaddr", bus_if.ramaddr, mon_e.addr);
                    chk("d_iwait_high", 32'(bus_if.iwait), 32'd1);
                    if (mon_e.wr) begin
                        chk("d_ramWEN", 32'(bus_if.ramWEN), 32'd1);
                        chk("d_ramstore", bus_if.ramstore, mon_e.data);
                    end else begin
                        chk("d_ramREN", 32'(bus_if.ramREN), 32'd1);
                    end
                    if (mon_e.bad) begin
                        chk("d_errword", bus_if.dload, ERR_WORD);
                        err_exp = 1'b1;
                    end else if (!mon_e.wr) begin
                        chk("d_dload", bus_if.dload, mon_e.data);
                    end
                end
            end else begin
                chk("d_load_idle_zero", bus_if.dload, 32'h0);
            end
            if (bus_if.iwait === 1'b0) begin
                i_done_cyc = cyc;
                if (i_q.size() == 0) begin
                    chk("i_unexpected_pulse", 32'(bus_if.iwait), 32'd1);
                end else begin
                    mon_e = i_q.pop_front();
                    chk("i_ramaddr", bus_if.ramaddr, mon_e.addr);
                    chk("i_ramREN", 32'(bus_if.ramREN), 32'd1);
                    chk("i_iload", bus_if.iload, mon_e.bad ? ERR_WORD : mon_e.data);
                    if (mon_e.bad) err_exp = 1'b1;
                end
            end else begin
                chk("i_load_idle_zero", bus_if.iload, 32'h0);
            end
        end
    end

    task automatic d_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        int   n;
        e.addr = addr;
        e.wr   = wr;
        e.bad  = is_bad(addr);
        if (wr) begin
            e.data = data;
            if (!e.bad) ref_mem[addr] = data;
        end else begin
            e.data = ref_rd(addr);
        end
        d_q.push_back(e);
        bus_if.daddr  = addr;
        bus_if.dstore = wr ? data : $urandom;
        bus_if.dWEN   = wr;
        bus_if.dREN   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.dwait && n < 64);
        if (bus_if.dwait) begin
            chk("d_timeout", 32'(bus_if.dwait), 32'd0);
            d_q.delete();
        end
        @(posedge clk);
        #1;
        bus_if.dWEN = 1'b0;
        bus_if.dREN = 1'b0;
    endtask

    task automatic i_txn(input logic [31:0] addr);
        exp_t e;
        int   n;
        e.addr = addr;
        e.wr   = 1'b0;
        e.bad  = is_bad(addr);
        e.data = ref_rd(addr);
        i_q.push_back(e);
        bus_if.iaddr = addr;
        bus_if.iREN  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.iwait && n < 64);
        if (bus_if.iwait) begin
            chk("i_timeout", 32'(bus_if.iwait), 32'd0);
            i_q.delete();
        end
        @(posedge clk);
        #1;
        bus_if.iREN = 1'b0;
    endtask

    // Raise a dcache read, keep the RAM busy, then withdraw the request.
    task automatic d_abort(input logic [31:0] addr);
        force_busy   = 1'b1;
        bus_if.daddr = addr;
        bus_if.dWEN  = 1'b0;
        bus_if.dREN  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_if.dREN = 1'b0;
        @(posedge clk);
        #1;
        force_busy = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc;
        int pulses_before;
        nrst            = 1'b0;
        bus_if.dREN     = 1'b0;
        bus_if.dWEN     = 1'b0;
        bus_if.daddr    = '0;
        bus_if.dstore   = '0;
        bus_if.iREN     = 1'b0;
        bus_if.iaddr    = '0;
        bus_if.ramload  = '0;
        bus_if.ramstate = 2'd0;

        #3;
        chk("rst_dwait", 32'(bus_if.dwait), 32'd1);
        chk("rst_iwait", 32'(bus_if.iwait), 32'd1);
        chk("rst_ramREN", 32'(bus_if.ramREN), 32'd0);
        chk("rst_ramWEN", 32'(bus_if.ramWEN), 32'd0);
        chk("rst_err", 32'(bus_if.err), 32'd0);
        chk("rst_dload", bus_if.dload, 32'h0);
        chk("rst_iload", bus_if.iload, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        nrst   = 1'b1;
        mon_en = 1'b1;
        gap(1);

        // Random mixed traffic from both caches
        max_busy = 3;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    int          op;
                    logic [31:0] a;
                    op = $urandom_range(0, 9);
                    a  = 32'h100 + 32'($urandom_range(0, 15));
                    if (op < 4)      d_txn(1'b1, a, $urandom);
                    else if (op < 9) d_txn(1'b0, a, 32'h0);
                    else             d_abort(a);
                    gap($urandom_range(0, 1));
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    i_txn(32'h8000_0000 + 32'($urandom_range(0, 15)));
                    gap($urandom_range(0, 2));
                end
            end
        join
        gap(2);

        // Same-cycle requests: the dcache must complete before the icache
        max_busy = 0;
        gap(1);
        fork
            d_txn(1'b0, 32'h104, 32'h0);
            i_txn(32'h8000_0004);
        join
        chk("prio_d_before_i", 32'(d_done_cyc < i_done_cyc), 32'd1);
        gap(2);

        // Starvation: continuous dcache reads against a pending icache read
        i_fin     = 1'b0;
        start_cyc = cyc;
        fork
            begin
                i_txn(32'h8000_0008);
                i_fin = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (!i_fin && n < 40) begin
                    d_txn(1'b0, 32'h100 + 32'($urandom_range(0, 14)), 32'h0);
                    n++;
                end
            end
        join
        chk("starve_bound", 32'((i_done_cyc - start_cyc) <= STARVE_MAX + 3), 32'd1);
        gap(2);

        // Error completion on a dcache read
        d_txn(1'b0, 32'h10F, 32'h0);
        gap(2);
        chk("err_sticky", 32'(bus_if.err), 32'd1);

        // Abort: a withdrawn read must drop the enables and produce no pulse
        pulses_before = d_pulses;
        d_abort(32'h104);
        gap(2);
        chk("abort_ramREN", 32'(bus_if.ramREN), 32'd0);
        chk("abort_no_pulse", 32'(d_pulses), 32'(pulses_before));

        // Asynchronous reset in the middle of a write
        force_busy    = 1'b1;
        bus_if.daddr  = 32'h120;
        bus_if.dstore = 32'h0000CAFE;
        bus_if.dWEN   = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_ramWEN", 32'(bus_if.ramWEN), 32'd1);
        nrst    = 1'b0;
        err_exp = 1'b0;
        #1;
        chk("arst_ramWEN", 32'(bus_if.ramWEN), 32'd0);
        chk("arst_dwait", 32'(bus_if.dwait), 32'd1);
        chk("arst_err", 32'(bus_if.err), 32'd0);
        bus_if.dWEN = 1'b0;
        force_busy  = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        gap(1);

        // The controller must still be usable after reset
        d_txn(1'b1, 32'h108, 32'h13572468);
        d_txn(1'b0, 32'h108, 32'h0);
        gap(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_mem_ctrl.md
Name: cache_mem_ctrl

Overview:
- Responder end of the cache-to-memory protocol. It services the dcache (dREN/dWEN/daddr/dstore, answered with dwait/dload) and the icache (iREN/iaddr, answered with iwait/iload).
- It arbitrates both caches onto a single-ported RAM that reports ramstate, and drives the RAM request lines.
- It sits between the cache pair and the RAM model / bus, in the position of the existing memory controller.

Parameters:
- STARVE_MAX, 8, consecutive cycles the icache may wait while dcache is granted before the icache is forced to win the next arbitration.
- ERR_WORD, 32'hBAD1BAD1, word returned on dload/iload when the RAM reports ERROR.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request
- daddr  input  32  dcache word address
- dstore  input  32  dcache write data
- dwait  output  1  low for exactly one cycle when the dcache access completes
- dload  output  32  dcache read data, valid while dwait is low
- iREN  input  1  icache read request
- iaddr  input  32  icache word address
- iwait  output  1  low for exactly one cycle when the icache access completes
- iload  output  32  icache read data, valid while iwait is low
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- err  output  1  sticky flag, set on any ERROR completion

Behaviour:
- Reset (asynchronous): state IDLE, dwait=1, iwait=1, ramREN=0, ramWEN=0, err=0, starve counter=0. Data outputs are 0 at reset. A reset mid-transaction abandons the access with no completion pulse.
- States: IDLE, DWR, DRD, IRD.
- IDLE, arbitration performed each cycle:
  - Default priority is dWEN > dREN > iREN.
  - If starve counter ≥ STARVE_MAX and iREN=1, go to IRD regardless of dcache requests.
  - dWEN and dREN both high is treated as a write.
  - With no request, remain in IDLE.
- No RAM request is issued in IDLE. Grant latency is 1 cycle, so the first RAM request cycle is the cycle after arbitration.
- DWR: ramWEN=1, ramaddr=daddr, ramstore=dstore.
- DRD: ramREN=1, ramaddr=daddr.
- IRD: ramREN=1, ramaddr=iaddr.
- Addresses and data pass through combinationally from the granted requester. The requester must hold them stable until its wait drops.
- Completion occurs in a granted state when ramstate is ACCESS or ERROR:
  - The granted wait goes low combinationally in that cycle.
  - dload/iload = ramload on ACCESS, or ERR_WORD on ERROR.
  - On ERROR, err is set next edge and stays set until reset.
  - The next state is IDLE.
- With ramstate FREE or BUSY, stay in the granted state with wait held high.
- Abort: if the granted requester deasserts its request before completion, return to IDLE next cycle and drop the RAM enables. No wait pulse is produced.
- Non-granted wait is always high. dload/iload are don't-care (drive 0) while their wait is high.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each cycle iREN=1 and state≠IRD.
  - Clears when IRD completes or when iREN=0.
- Back-to-back accesses: each transaction costs at least 2 cycles (IDLE arbitration + 1 ACCESS cycle). A two-word cache block fill therefore takes at least 4 cycles with an always-ACCESS RAM.
- Write-then-read to the same address in consecutive transactions must return the written data; there is no internal buffering, so this holds by RAM ordering.

Test Plan:
- Single dcache read: dREN=1, daddr=0x40, RAM ACCESS on first request cycle with ramload=0x12345678 → ramREN=1 and ramaddr=0x40 in cycle 2; dwait=0 and dload=0x12345678 in cycle 2; iwait=1 throughout.
- Write latency: dWEN=1, daddr=0x3100, dstore=0xCAFE, RAM BUSY for 3 cycles then ACCESS → ramWEN=1 held for 4 cycles; ramstore=0xCAFE; dwait low only in the 4th request cycle.
- Simultaneous requests: iREN and dREN raised in the same cycle → dcache served first. The icache is then granted at the next IDLE, and its iwait low pulse occurs after the dwait pulse.
- Starvation: iREN held high while the dcache issues continuous reads, always-ACCESS RAM → the icache is granted no later than the arbitration after its counter reaches 8. iload is correct and the counter returns to 0.
- Error and abort:
  - ramstate=ERROR on a dcache read → dwait=0, dload=0xBAD1BAD1, err=1 and staying 1.
  - Separately, dREN dropped during BUSY → return to IDLE, no dwait pulse.
- Async reset: nRST asserted mid-DWR → ramWEN=0, dwait=1 and err=0 immediately, without waiting for a clock edge.
